// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;
  localparam int CNT_W_DEF = 25;
  localparam int SYS_HZ    = 50_000_000;
  localparam int TC_1KHZ   = 24999;
  localparam int TC_50HZ   = 499999;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: terminal-count configuration bus.
interface clk_div_multi_if import clk_div_pkg::*; #(
  parameter int N_CH  = 2,
  parameter int CNT_W = CNT_W_DEF
) ();
  localparam int CH_W = ch_w(N_CH);
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_tc;
  logic             cfg_ack;
  modport master(output cfg_wr, cfg_ch, cfg_tc, input cfg_ack);
  modport slave(input cfg_wr, cfg_ch, cfg_tc, output cfg_ack);
endinterface

// File: rtl/clk_div_ch.sv
// clk_div_ch: one 50% duty divider channel with shadowed terminal count.
module clk_div_ch #(
  parameter int               CNT_W = 25,
  parameter logic [CNT_W-1:0] INIT  = '0
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             clk_out_o,
  output logic             tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, t_q, t_d, sh_q, sh_d;
  logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, term, apply;
  // New T takes effect only at a toggle or sync, so no half-period is cut short.
  always_comb begin
    term   = cnt_q == t_q;
    apply  = sync_i || (en_i && term);
    cnt_d  = sync_i ? '0 : !en_i ? cnt_q : term ? '0 : cnt_q + CNT_W'(1);
    clk_d  = sync_i ? 1'b0 : (en_i && term) ? ~clk_q : clk_q;
    tick_d = !sync_i && en_i && term && !clk_q;
    t_d    = (apply && pend_q) ? sh_q : t_q;
    pend_d = wr_i || (pend_q && !apply);
    sh_d   = wr_i ? tc_i : sh_q;
  end
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      cnt_q  <= '0;
      t_q    <= INIT;
      sh_q   <= INIT;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      t_q    <= t_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent clock dividers with runtime terminal-count writes.
module clk_div_multi import clk_div_pkg::*; #(
  parameter int                    N_CH    = 2,
  parameter int                    CNT_W   = CNT_W_DEF,
  parameter logic [N_CH*CNT_W-1:0] INIT_TC = {CNT_W'(TC_50HZ), CNT_W'(TC_1KHZ)}
) (
  input  logic            clk_in,
  input  logic            rst,
  input  logic [N_CH-1:0] en,
  input  logic            sync,
  clk_div_multi_if.slave  cfg,
  output logic [N_CH-1:0] clk_out,
  output logic [N_CH-1:0] tick
);
  logic wr_ok, ack_q, ack_d;
  always_comb begin
    wr_ok = cfg.cfg_wr && (32'(cfg.cfg_ch) < N_CH);
    ack_d = wr_ok;
  end
  always_ff @(posedge clk_in or posedge rst)
    if (rst) ack_q <= 1'b0;
    else     ack_q <= ack_d;
  assign cfg.cfg_ack = ack_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W), .INIT(INIT_TC[i*CNT_W +: CNT_W])) u_ch (
      .clk_in    (clk_in),
      .rst       (rst),
      .en_i      (en[i]),
      .sync_i    (sync),
      .wr_i      (wr_ok && (32'(cfg.cfg_ch) == i)),
      .tc_i      (cfg.cfg_tc),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i])
    );
  end
endmodule
